pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load/RAW stalls, branch flushes and data-memory wait freezes.
// Define HAZARD_FWD_EN when forwarding exists, so only load-use dependencies stall.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_src_valid,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_freeze,
  output logic        if_freeze,
  output logic        if_flush,
  output logic        id_flush,
  output logic        pipe_freeze,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             pending_br_q, pending_br_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             exe_match;
  logic             haz;
  logic             unused_ok;

  assign exe_match = id_src_valid &
                     ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load consumed next cycle must stall.
  assign haz       = exe_wb_en & exe_mem_read & exe_match;
  assign unused_ok = ^{mem_dest, mem_wb_en};
`else
  logic mem_match;
  assign mem_match = id_src_valid &
                     ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
  assign haz       = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
  assign unused_ok = exe_mem_read;
`endif

  // Next-state and Mealy outputs
  always_comb begin
    state_d      = state_q;
    pending_br_d = pending_br_q;
    pc_freeze    = 1'b0;
    if_freeze    = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        pc_freeze   = 1'b1;
        if_freeze   = 1'b1;
        pipe_freeze = 1'b1;
        state_d     = S_MEM_WAIT;
        // A branch resolved while frozen, or an interrupted flush, is owed later.
        if ((state_q == S_MEM_WAIT && branch_taken) || state_q == S_FLUSH) begin
          pending_br_d = 1'b1;
        end
      end else begin
        case (state_q)
          S_FLUSH: begin
            if_flush     = 1'b1;
            id_flush     = 1'b1;
            pending_br_d = 1'b0;
            state_d      = S_RUN;
          end
          S_MEM_WAIT: begin
            if (haz) begin
              pc_freeze = 1'b1;
              if_freeze = 1'b1;
              id_flush  = 1'b1;
            end
            state_d = (pending_br_q | branch_taken) ? S_FLUSH : S_RUN;
          end
          default: begin
            if (branch_taken) begin
              if_flush = 1'b1;
              id_flush = 1'b1;
            end else if (haz) begin
              pc_freeze = 1'b1;
              if_freeze = 1'b1;
              id_flush  = 1'b1;
            end
            state_d = S_RUN;
          end
        endcase
      end
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_freeze && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_RUN;
      pending_br_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_br_q <= pending_br_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
